// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if
//   Bundles the requester handshakes, the transmitter hookup and the grant
//   status of uart_tx_arbiter into one bundle.
//   master : requester/transmitter side (drives req_*, tx_done)
//   slave  : the arbiter (drives req_ready, req_ack, send_en, status)
//
// Handshake: a byte on lane i transfers in the cycle where req_valid[i] and
// req_ready[i] are both high. req_ready is a one-cycle strobe that the
// arbiter raises only while req_valid[i] is high; the requester holds
// req_valid/req_data/req_last stable until that cycle. After the strobe the
// requester may present its next byte or drop req_valid.
interface uart_tx_arbiter_if #(
   parameter int NUM_REQ = 4
);
   localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [NUM_REQ-1:0]   req_valid;
   logic [8*NUM_REQ-1:0] req_data;
   logic [NUM_REQ-1:0]   req_last;
   logic [NUM_REQ-1:0]   req_ready;
   logic [NUM_REQ-1:0]   req_ack;
   logic                 send_en;
   logic [7:0]           data_byte_tx;
   logic                 tx_done;
   logic                 grant_valid;
   logic [IDW-1:0]       grant_id;
   logic                 busy;
   logic                 timeout_err;
   // Debug view of the scheduler: FSM state and round-robin pointer.
   logic [1:0]           dbg_state;
   logic [IDW-1:0]       dbg_rr_ptr;

   modport master (
      output req_valid, req_data, req_last, tx_done,
      input  req_ready, req_ack, send_en, data_byte_tx,
             grant_valid, grant_id, busy, timeout_err, dbg_state, dbg_rr_ptr
   );

   modport slave (
      input  req_valid, req_data, req_last, tx_done,
      output req_ready, req_ack, send_en, data_byte_tx,
             grant_valid, grant_id, busy, timeout_err, dbg_state, dbg_rr_ptr
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Round-robin scheduler sharing one UART transmitter between NUM_REQ
//   requesters. One byte is in flight at a time: accept, pulse send_en,
//   wait for tx_done. A requester keeps the grant across a packet until its
//   last byte is acknowledged. A watchdog aborts a WAIT or HOLD that lasts
//   TIMEOUT_CYC cycles.
// Ports:
//   clk, nrst : clock, asynchronous active-low reset
//   bus       : uart_tx_arbiter_if.slave (requester handshakes, send_en /
//               data_byte_tx / tx_done, grant status, debug state/pointer)
module uart_tx_arbiter #(
   parameter int NUM_REQ     = 4,
   parameter int TIMEOUT_CYC = 100000
) (
   input logic              clk,
   input logic              nrst,
   uart_tx_arbiter_if.slave bus
);
   localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int WDW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYC - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_WAIT = 2'd2,
      ST_HOLD = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
   logic [IDW-1:0]   grant_id_q, grant_id_d;
   logic [7:0]       data_q, data_d;
   logic             last_q, last_d;
   logic [WDW-1:0]   wd_q, wd_d;

   logic             rr_found;
   logic [IDW-1:0]   rr_sel;
   logic [IDW-1:0]   rr_next;
   logic             wd_expired;
   logic [NUM_REQ-1:0] ready_c;
   logic [NUM_REQ-1:0] ack_c;
   logic             timeout_c;

   // First valid requester at or after rr_ptr, wrapping.
   always_comb begin
      rr_found = 1'b0;
      rr_sel   = rr_ptr_q;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!rr_found && bus.req_valid[(int'(rr_ptr_q) + k) % NUM_REQ]) begin
            rr_found = 1'b1;
            rr_sel   = IDW'((int'(rr_ptr_q) + k) % NUM_REQ);
         end
      end
   end

   assign rr_next    = IDW'((int'(grant_id_q) + 1) % NUM_REQ);
   assign wd_expired = (wd_q == WD_LAST);

   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      grant_id_d = grant_id_q;
      data_d     = data_q;
      last_d     = last_q;
      wd_d       = wd_q;
      ready_c    = '0;
      ack_c      = '0;
      timeout_c  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            wd_d = '0;
            if (rr_found) begin
               ready_c[rr_sel] = 1'b1;
               data_d          = bus.req_data[8*int'(rr_sel) +: 8];
               last_d          = bus.req_last[rr_sel];
               grant_id_d      = rr_sel;
               state_d         = ST_SEND;
            end
         end
         ST_SEND: begin
            wd_d    = '0;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            // tx_done wins over a simultaneous watchdog expiry.
            if (bus.tx_done) begin
               ack_c[grant_id_q] = 1'b1;
               wd_d              = '0;
               if (last_q) begin
                  rr_ptr_d = rr_next;
                  state_d  = ST_IDLE;
               end else begin
                  state_d  = ST_HOLD;
               end
            end else if (wd_expired) begin
               timeout_c = 1'b1;
               rr_ptr_d  = rr_next;
               state_d   = ST_IDLE;
            end else begin
               wd_d = wd_q + 1'b1;
            end
         end
         ST_HOLD: begin
            // Packet lock: only the current owner can be accepted here.
            if (bus.req_valid[grant_id_q]) begin
               ready_c[grant_id_q] = 1'b1;
               data_d              = bus.req_data[8*int'(grant_id_q) +: 8];
               last_d              = bus.req_last[grant_id_q];
               state_d             = ST_SEND;
            end else if (wd_expired) begin
               timeout_c = 1'b1;
               rr_ptr_d  = rr_next;
               state_d   = ST_IDLE;
            end else begin
               wd_d = wd_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q    <= ST_IDLE;
         rr_ptr_q   <= '0;
         grant_id_q <= '0;
         data_q     <= '0;
         last_q     <= 1'b0;
         wd_q       <= '0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         grant_id_q <= grant_id_d;
         data_q     <= data_d;
         last_q     <= last_d;
         wd_q       <= wd_d;
      end
   end

   // Strobes are gated by nrst so nothing is accepted or acked while reset
   // is held, even though they are decoded from live inputs.
   assign bus.req_ready    = ready_c & {NUM_REQ{nrst}};
   assign bus.req_ack      = ack_c & {NUM_REQ{nrst}};
   assign bus.timeout_err  = timeout_c & nrst;
   assign bus.send_en      = (state_q == ST_SEND);
   assign bus.data_byte_tx = data_q;
   assign bus.grant_valid  = (state_q != ST_IDLE);
   assign bus.grant_id     = grant_id_q;
   assign bus.busy         = (state_q != ST_IDLE);
   assign bus.dbg_state    = state_q;
   assign bus.dbg_rr_ptr   = rr_ptr_q;
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Round-robin scheduler that shares the single UART transmitter among NUM_REQ requesters.
- Accepts bytes over per-requester valid/ready handshakes and issues one send_en pulse per byte. Waits for tx_done before issuing the next.
- A requester keeps the grant for the whole of a multi-byte packet until it marks the last byte.
- A watchdog recovers if tx_done never arrives or a packet owner stalls.

Parameters:
- NUM_REQ, 4, number of requesters (2..8); ID width IDW = $clog2(NUM_REQ).
- TIMEOUT_CYC, 100000, cycles allowed in WAIT or HOLD before abort. Must exceed one 9600-baud frame at the system clock.

Ports:
- clk  input  1  system clock
- nrst  input  1  asynchronous active-low reset
- req_valid  input  NUM_REQ  requester i has a byte
- req_data  input  8*NUM_REQ  byte i at bits [8i+7:8i]
- req_last  input  NUM_REQ  byte is final byte of packet i
- req_ready  output  NUM_REQ  one-cycle accept strobe to requester i
- req_ack  output  NUM_REQ  one-cycle pulse: byte from i fully transmitted
- send_en  output  1  one-cycle start pulse to transmitter
- data_byte_tx  output  8  byte to transmitter, held stable from send_en until tx_done
- tx_done  input  1  one-cycle pulse from transmitter after stop bit
- grant_valid  output  1  a packet owner exists (states SEND/WAIT/HOLD)
- grant_id  output  IDW  current/last owner
- busy  output  1  state != IDLE
- timeout_err  output  1  one-cycle pulse on watchdog abort

Behaviour:
- Reset: all outputs 0, state IDLE, rr_ptr = 0, watchdog counter = 0. Reset mid-transfer aborts immediately; no ack is issued.
- Round-robin selection: search req_valid starting at rr_ptr, ascending and wrapping modulo NUM_REQ. The first set bit is g.
- rr_ptr updates to (g+1) mod NUM_REQ only when a packet ends (last byte acked, or timeout).
- IDLE: if any req_valid, select g, assert req_ready[g] for that cycle only, latch req_data[g] and req_last[g], set grant_id = g, and go to SEND.
- SEND (1 cycle): send_en = 1, data_byte_tx = latched byte, clear watchdog, go to WAIT.
- WAIT: watchdog increments each cycle.
  - tx_done: pulse req_ack[g]. If the latched last = 1, go to IDLE (grant_valid drops, rr_ptr advances). Otherwise clear the watchdog and go to HOLD.
  - Watchdog reaches TIMEOUT_CYC-1 with no tx_done: pulse timeout_err, no ack, go to IDLE, rr_ptr advances.
- HOLD: only requester g is considered; other valids are ignored.
  - req_valid[g]: req_ready[g] = 1, latch byte and last, go to SEND.
  - Watchdog expiry: timeout_err pulse, go to IDLE, rr_ptr advances.
- Latency: byte accepted in IDLE/HOLD cycle N → send_en at N+1. tx_done at cycle M → req_ack at M (combinational from state), next accept earliest M+1.
- tx_done outside WAIT is ignored.
- A tx_done in the same cycle as watchdog expiry counts as done: no error.
- At most one req_ready bit and at most one req_ack bit are ever high; send_en is never high in two consecutive cycles.
- Requesters must hold req_valid/req_data stable until req_ready. Deasserting valid before ready is permitted in IDLE (no grant) and stalls HOLD until timeout.
- Expected size: approx. 200 lines of RTL. One-hot or rotate-and-priority-encode RR, 17-bit watchdog counter for the default.

Test Plan:
- Single byte: req_valid=4'b0001, req_data[7:0]=8'hA5, last=1 → ready[0] 1 cycle; send_en next cycle with data 8'hA5; after tx_done: ack[0], busy=0, rr_ptr=1.
- Fairness: all four valid continuously, last=1 on every byte → grant order 0,1,2,3,0 over five transfers; each grant is separated by a tx_done.
- Packet lock: req 2 sends 8'h11,8'h22,8'h33 with last only on 8'h33 while req 1 is also valid → all three bytes go out before req 1 is granted. Next grant after packet is 3 if valid, otherwise wraps to 1.
- TX timeout: withhold tx_done with TIMEOUT_CYC=16 → timeout_err at 16th WAIT cycle, no ack, state IDLE, next requester is granted.
- HOLD stall: req 0 sends 8'h01 with last=0 then drops valid, TIMEOUT_CYC=16 → timeout_err after 16 HOLD cycles; req 3 waiting is then granted.
- Reset mid-WAIT: nrst low during WAIT → send_en, req_ready, req_ack, busy all 0 immediately, rr_ptr=0; a later tx_done causes no ack.
